// File: rtl/pid_sample_scheduler_if.sv
// Handshake and data bundle between the sample scheduler (master) and the PID core (slave).
// Data fields carry two's-complement values; signedness is applied by the consumer.
interface pid_sample_scheduler_if;
  logic [15:0] o_pid_sp;
  logic [15:0] o_pid_pv;
  logic        o_pid_start;
  logic        i_pid_valid;
  logic [31:0] i_pid_un;

  modport master (
    output o_pid_sp,
    output o_pid_pv,
    output o_pid_start,
    input  i_pid_valid,
    input  i_pid_un
  );

  modport slave (
    input  o_pid_sp,
    input  o_pid_pv,
    input  o_pid_start,
    output i_pid_valid,
    output i_pid_un
  );
endinterface

// File: rtl/pid_sample_scheduler.sv
// Fixed-rate PID sequencer: latches sp/pv on each sample tick, starts the PID, waits for its
// valid rising edge (with timeout) and clamps the 32-bit result to the 16-bit actuator range.
module pid_sample_scheduler #(
  parameter int                 DIV_W = 16,
  parameter int                 TMO   = 64,
  parameter logic signed [15:0] UMAX  = 16'sh7FFF,
  parameter logic signed [15:0] UMIN  = 16'sh8001
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic [DIV_W-1:0]       i_period,
  input  logic [15:0]            i_sp,
  input  logic [15:0]            i_pv,
  input  logic                   i_clr_err,
  pid_sample_scheduler_if.master pid,
  output logic [15:0]            o_u,
  output logic                   o_u_valid,
  output logic                   o_sat,
  output logic                   o_overrun,
  output logic                   o_timeout
);

  localparam int TMO_W = $clog2(TMO + 1);
  localparam logic signed [31:0] UMAX_X = {{16{UMAX[15]}}, UMAX};
  localparam logic signed [31:0] UMIN_X = {{16{UMIN[15]}}, UMIN};

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    LAUNCH,
    WAIT_RESULT,
    OUTPUT
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              vld_q;
  logic [15:0]       sp_q, pv_q;
  logic [15:0]       u_q;
  logic              u_valid_q;
  logic              sat_q;
  logic              overrun_q;
  logic              timeout_q;

  logic              cnt_zero;
  logic [DIV_W-1:0]  period_m1;
  logic              tick;
  logic              busy;
  logic              overrun_set;
  logic              vld_rise;
  logic              accept;
  logic              tmo_expire;
  logic signed [31:0] un_s;
  logic [15:0]       clamp_u;
  logic              clamp_sat;

  assign cnt_zero    = (cnt_q == '0);
  assign period_m1   = (i_period == '0) ? '0 : i_period - DIV_W'(1);
  assign tick        = (state_q == WAIT_TICK) && i_enable && cnt_zero;
  assign busy        = (state_q == LAUNCH) || (state_q == WAIT_RESULT) || (state_q == OUTPUT);
  assign overrun_set = i_enable && cnt_zero && busy;
  // vld_q also tracks during LAUNCH, so a level already high at start never counts as an edge.
  assign vld_rise    = pid.i_pid_valid & ~vld_q;
  assign accept      = (state_q == WAIT_RESULT) && vld_rise;
  assign tmo_expire  = (state_q == WAIT_RESULT) && !vld_rise && (tmo_q == TMO_W'(TMO - 1));

  always_comb begin
    un_s      = $signed(pid.i_pid_un);
    clamp_u   = pid.i_pid_un[15:0];
    clamp_sat = 1'b0;
    if (un_s > UMAX_X) begin
      clamp_u   = UMAX;
      clamp_sat = 1'b1;
    end else if (un_s < UMIN_X) begin
      clamp_u   = UMIN;
      clamp_sat = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (i_enable) state_d = WAIT_TICK;
      WAIT_TICK: begin
        if (!i_enable)  state_d = IDLE;
        else if (tick)  state_d = LAUNCH;
      end
      LAUNCH:      state_d = WAIT_RESULT;
      WAIT_RESULT: begin
        if (accept)          state_d = OUTPUT;
        else if (tmo_expire) state_d = WAIT_TICK;
      end
      OUTPUT:      state_d = i_enable ? WAIT_TICK : IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      vld_q     <= 1'b0;
      sp_q      <= '0;
      pv_q      <= '0;
      u_q       <= '0;
      u_valid_q <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= pid.i_pid_valid;

      if (!i_enable)     cnt_q <= '0;
      else if (cnt_zero) cnt_q <= period_m1;
      else               cnt_q <= cnt_q - DIV_W'(1);

      if (tick) begin
        sp_q <= i_sp;
        pv_q <= i_pv;
      end

      if (state_q == LAUNCH)                  tmo_q <= '0;
      else if (state_q == WAIT_RESULT && !accept) tmo_q <= tmo_q + TMO_W'(1);

      // Result captured on the edge cycle so o_u and o_u_valid appear one clock later.
      u_valid_q <= accept;
      if (accept) begin
        u_q   <= clamp_u;
        sat_q <= clamp_sat;
      end

      if (overrun_set)    overrun_q <= 1'b1;
      else if (i_clr_err) overrun_q <= 1'b0;

      if (tmo_expire)     timeout_q <= 1'b1;
      else if (i_clr_err) timeout_q <= 1'b0;
    end
  end

  assign pid.o_pid_sp    = sp_q;
  assign pid.o_pid_pv    = pv_q;
  assign pid.o_pid_start = (state_q == LAUNCH);
  assign o_u             = u_q;
  assign o_u_valid       = u_valid_q;
  assign o_sat           = sat_q;
  assign o_overrun       = overrun_q;
  assign o_timeout       = timeout_q;

endmodule
